// File: rtl/mem_access_unit.sv
// Load/store controller between the datapath and a single-port word RAM with registered read.
// Define MAU_SUBWORD_EN to enable byte/half loads and read-modify-write sub-word stores.
module mem_access_unit #(
    parameter int ADDR_LIMIT = 1024,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_write,
    output logic              ram_write_en,
    output logic              ram_read_en,
    input  logic [DATA_W-1:0] ram_data_in
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(ADDR_LIMIT);

    logic [2:0]        state_reg, state_next;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_data;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = (req_addr >= LIMIT);
`ifdef MAU_SUBWORD_EN
        case (req_size)
            2'b00:   req_err = req_err;
            2'b01:   req_err = req_err || req_addr[0];
            2'b10:   req_err = req_err || (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
`else
        req_err = req_err || (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = S_RESP;
                    else if (req_we && (req_size == 2'b10))
                        state_next = S_WR;
                    else
                        state_next = S_RD;
                end
            end
            S_RD:      state_next = S_RD_WAIT;
            S_RD_WAIT: state_next = we_reg ? S_WR : S_RESP;
            S_WR:      state_next = S_RESP;
            S_RESP:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Aligned requests make this shift equal to the little-endian lane select for every size.
    assign lane_data = ram_data_in >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (size_reg)
            2'b00:   load_data = unsigned_reg ? {{(DATA_W-8){1'b0}}, lane_data[7:0]}
                                              : {{(DATA_W-8){lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = unsigned_reg ? {{(DATA_W-16){1'b0}}, lane_data[15:0]}
                                              : {{(DATA_W-16){lane_data[15]}}, lane_data[15:0]};
            default: load_data = lane_data;
        endcase
    end

`ifdef MAU_SUBWORD_EN
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] wdata_rep;

    always_comb begin
        case (size_reg)
            2'b00: begin
                lane_mask = 4'b0001 << addr_reg[1:0];
                wdata_rep = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                lane_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_reg[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata_rep = wdata_reg;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_data[8*gi +: 8] = lane_mask[gi] ? wdata_rep[8*gi +: 8]
                                                      : ram_data_in[8*gi +: 8];
    end
`else
    assign merged_data = wdata_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg       <= req_we;
                size_reg     <= req_size;
                unsigned_reg <= req_unsigned;
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                rdata_reg    <= '0;
                err_reg      <= req_err;
            end else if (state_reg == S_RD_WAIT) begin
                if (we_reg)
                    wdata_reg <= merged_data;
                else
                    rdata_reg <= load_data;
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them immediately.
    assign req_ready      = rst_n && (state_reg == S_IDLE);
    assign resp_valid     = (state_reg == S_RESP);
    assign resp_rdata     = resp_valid ? rdata_reg : '0;
    assign resp_err       = resp_valid && err_reg;
    assign ram_read_en    = (state_reg == S_RD);
    assign ram_write_en   = (state_reg == S_WR);
    assign ram_address    = {addr_reg[DATA_W-1:2], 2'b00};
    assign ram_data_write = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a word RAM model with one-cycle registered read.
// Sub-word checks follow MAU_SUBWORD_EN; without it, sub-word requests are expected to error.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic [31:0] ram_data_write;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [31:0] ram_data_in;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int both_cnt   = 0;
    logic ram_init;
    logic [31:0] mem [0:255];

    mem_access_unit #(.ADDR_LIMIT(1024), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_address(ram_address), .ram_data_write(ram_data_write),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_data_in(ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: mem[i] starts at 4*i, so a word load returns its own byte address.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 4);
            ram_data_in <= '0;
        end else begin
            if (ram_write_en) mem[ram_address[9:2]] <= ram_data_write;
            if (ram_read_en)  ram_data_in <= mem[ram_address[9:2]];
        end
    end

    always @(posedge clk) begin
        if (ram_read_en || ram_write_en) strobe_cnt++;
        if (ram_read_en && ram_write_en) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge inside cycle T+1 (T = handshake cycle).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check("ready_at_issue", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic load_check(input string tag, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, uns, addr, 32'h0);
        check({tag, "_rd_en"}, 32'(ram_read_en), 32'd1);
        @(negedge clk);
        check({tag, "_wait"}, 32'({ram_read_en, ram_write_en, resp_valid}), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_rdata"}, resp_rdata, exp);
        check({tag, "_err"}, 32'(resp_err), 32'd0);
        $display("load %s addr=0x%08h size=%0d rdata=0x%08h", tag, addr, size, resp_rdata);
    endtask

    task automatic err_check(input string tag, input logic we, input logic [1:0] size,
                             input logic [31:0] addr);
        int snap;
        snap = strobe_cnt;
        issue(we, size, 1'b0, addr, 32'h1234_5678);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_err"}, 32'(resp_err), 32'd1);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_nostrobe"}, 32'(strobe_cnt - snap), 32'd0);
        $display("error %s addr=0x%08h size=%0d", tag, addr, size);
    endtask

    initial begin
        int acc, rsp, viol, snap;
        rst_n = 1'b0; ram_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_outputs", 32'({resp_valid, resp_err, ram_read_en, ram_write_en}), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_addr", ram_address, 32'd0);
        ram_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        $display("reset released");

        load_check("lw_0x8", 2'b10, 1'b0, 32'h8, 32'h0000_0008);
        @(negedge clk);
        check("lw_back_idle", 32'({req_ready, resp_valid}), 32'b10);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("sw_wr_en", 32'(ram_write_en), 32'd1);
        check("sw_rd_en", 32'(ram_read_en), 32'd0);
        check("sw_addr", ram_address, 32'h10);
        check("sw_data", ram_data_write, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_wr_once", 32'(ram_write_en), 32'd0);
        check("sw_resp", 32'({resp_valid, resp_err}), 32'b10);
        check("sw_rdata", resp_rdata, 32'd0);
        $display("store word addr=0x10 data=0xdeadbeef");
        load_check("lw_0x10", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

        err_check("oob_0x400", 1'b0, 2'b10, 32'h400);
        err_check("misalign_w_0x6", 1'b0, 2'b10, 32'h6);
        err_check("illegal_size", 1'b0, 2'b11, 32'h0);

        // Reset during a write-bound operation must never reach the RAM.
`ifdef MAU_SUBWORD_EN
        issue(1'b1, 2'b00, 1'b0, 32'h8, 32'h55);
        check("rst_rmw_rd", 32'(ram_read_en), 32'd1);
        @(negedge clk);
`else
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
        check("rst_sw_wr", 32'(ram_write_en), 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", 32'({ram_read_en, ram_write_en, resp_valid}), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        snap = strobe_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_nostrobe", 32'(strobe_cnt - snap), 32'd0);
        check("midrst_idle", 32'(req_ready), 32'd1);
        check("midrst_addr", ram_address, 32'd0);
        check("midrst_wdata", ram_data_write, 32'd0);
        $display("reset mid-operation");
        load_check("lw_after_rst", 2'b10, 1'b0, 32'h8, 32'h0000_0008);

`ifdef MAU_SUBWORD_EN
        issue(1'b1, 2'b00, 1'b0, 32'h9, 32'hAB);
        check("sb_rd_en", 32'(ram_read_en), 32'd1);
        check("sb_addr", ram_address, 32'h8);
        @(negedge clk);
        check("sb_wait", 32'({ram_read_en, ram_write_en}), 32'd0);
        @(negedge clk);
        check("sb_wr_en", 32'(ram_write_en), 32'd1);
        check("sb_merge", ram_data_write, 32'h0000_AB08);
        @(negedge clk);
        check("sb_resp", 32'({resp_valid, resp_err}), 32'b10);
        $display("store byte addr=0x9 merged=0x0000ab08");
        load_check("lb_s_0x9", 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAB);
        load_check("lb_u_0x9", 2'b00, 1'b1, 32'h9, 32'h0000_00AB);
        load_check("lh_s_0x8", 2'b01, 1'b0, 32'h8, 32'hFFFF_AB08);
        load_check("lh_u_0xa", 2'b01, 1'b1, 32'hA, 32'h0000_0000);
        err_check("misalign_h_0x9", 1'b0, 2'b01, 32'h9);
        issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h9999_1234);
        @(negedge clk);
        @(negedge clk);
        check("sh_merge", ram_data_write, 32'h1234_AB08);
        @(negedge clk);
        $display("store half addr=0xa merged=0x1234ab08");
        load_check("lw_after_sh", 2'b10, 1'b0, 32'h8, 32'h1234_AB08);
`else
        err_check("lb_disabled", 1'b0, 2'b00, 32'h9);
        err_check("sh_disabled", 1'b1, 2'b01, 32'h8);
        load_check("lw_unchanged", 2'b10, 1'b0, 32'h8, 32'h0000_0008);
`endif

        // req_valid held high: a load occupies 4 cycles, so 12 cycles give 3 accepts and 3 responses.
        @(negedge clk);
        acc = 0; rsp = 0; viol = 0;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                if (resp_rdata !== 32'hDEAD_BEEF) viol++;
            end
            if (req_ready && (ram_read_en || ram_write_en || resp_valid)) viol++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("hold_accepts", 32'(acc), 32'd3);
        check("hold_resps", 32'(rsp), 32'd3);
        check("hold_ready_busy", 32'(viol), 32'd0);
        $display("held valid: accepts=%0d responses=%0d", acc, rsp);

        check("no_rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
